// File: rtl/seg7_scan_controller.sv
// Two-digit 7-segment scan controller: snapshots tens/ones, time-shares one registered
// decoder between the digits, then updates both active-low digit outputs on the same edge.
module seg7_scan_controller #(
  parameter int REFRESH_CYCLES = 250000,
  parameter int DEC_LATENCY    = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [3:0] i_Tens,
  input  logic [3:0] i_Ones,
  input  logic       i_Update,
  input  logic       i_Blank_Lead,
  output logic [3:0] o_Dec_Num,
  input  logic [6:0] i_Dec_Segments,
  output logic [6:0] o_Segment1,
  output logic [6:0] o_Segment2,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam int CW = $clog2(REFRESH_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    DEC_T,
    WAIT_T,
    DEC_O,
    WAIT_O,
    COMMIT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_refresh;
  logic          r_pending;
  logic          r_blank_snap;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    r_tens_snap;
  logic [3:0]    r_ones_snap;
  logic [3:0]    r_dec_num;
  logic [1:0]    r_wait;
  logic [6:0]    r_tens_shadow;
  logic [6:0]    r_seg1;
  logic [6:0]    r_seg2;

  logic w_wrap;
  logic w_idle;
  logic w_start;
  logic w_lat_done;
  logic w_blank_tens;

  assign w_wrap       = (r_refresh == CW'(REFRESH_CYCLES - 1));
  assign w_idle       = (r_state == IDLE);
  assign w_start      = w_idle && (w_wrap || i_Update || r_pending);
  assign w_lat_done   = (r_wait == 2'(DEC_LATENCY - 1));
  assign w_blank_tens = r_blank_snap && (r_tens_snap == 4'd0);

  // Refresh timer restarts on every scan start, so a manual update also defers the next rescan.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_refresh <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_start || w_wrap) begin
        r_refresh <= '0;
      end else begin
        r_refresh <= r_refresh + CW'(1);
      end
      if (w_start) begin
        r_pending <= 1'b0;
      end else if (i_Update && !w_idle) begin
        r_pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_state       <= IDLE;
      r_tens_snap   <= 4'd0;
      r_ones_snap   <= 4'd0;
      r_blank_snap  <= 1'b0;
      r_dec_num     <= 4'd0;
      r_wait        <= 2'd0;
      r_tens_shadow <= 7'h00;
      r_seg1        <= 7'h7F;
      r_seg2        <= 7'h7F;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_tens_snap  <= i_Tens;
            r_ones_snap  <= i_Ones;
            r_blank_snap <= i_Blank_Lead;
            r_dec_num    <= i_Tens;
            r_busy       <= 1'b1;
            r_state      <= DEC_T;
          end
        end
        DEC_T: begin
          r_wait  <= 2'd0;
          r_state <= WAIT_T;
        end
        WAIT_T: begin
          if (w_lat_done) begin
            // The blanked slot still spends its decode time so scan length never varies.
            r_tens_shadow <= w_blank_tens ? 7'h00 : i_Dec_Segments;
            r_dec_num     <= r_ones_snap;
            r_state       <= DEC_O;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        DEC_O: begin
          r_wait  <= 2'd0;
          r_state <= WAIT_O;
        end
        WAIT_O: begin
          if (w_lat_done) begin
            r_seg1  <= ~r_tens_shadow;
            r_seg2  <= ~i_Dec_Segments;
            r_done  <= 1'b1;
            r_state <= COMMIT;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        COMMIT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_Dec_Num  = r_dec_num;
  assign o_Segment1 = r_seg1;
  assign o_Segment2 = r_seg2;
  assign o_Busy     = r_busy;
  assign o_Done     = r_done;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Bench for seg7_scan_controller: scan-level reference model checked every cycle,
// plus directed scenarios with hand-computed segment patterns and timings.
module tb_seg7_scan_controller;
  localparam int RC = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tens = 4'd0;
  logic [3:0] ones = 4'd0;
  logic       upd = 1'b0;
  logic       blank = 1'b0;
  logic [3:0] dec_num;
  logic [6:0] dec_seg = 7'h00;
  logic [6:0] seg1;
  logic [6:0] seg2;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  seg7_scan_controller #(.REFRESH_CYCLES(RC), .DEC_LATENCY(1)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Tens(tens), .i_Ones(ones),
    .i_Update(upd), .i_Blank_Lead(blank), .o_Dec_Num(dec_num),
    .i_Dec_Segments(dec_seg), .o_Segment1(seg1), .o_Segment2(seg2),
    .o_Busy(busy), .o_Done(done)
  );

  always #5 clk = ~clk;

  // Standard active-high A..G table
  logic [6:0] lut [16];
  initial begin
    lut[0]  = 7'h7E; lut[1]  = 7'h30; lut[2]  = 7'h6D; lut[3]  = 7'h79;
    lut[4]  = 7'h33; lut[5]  = 7'h5B; lut[6]  = 7'h5F; lut[7]  = 7'h70;
    lut[8]  = 7'h7F; lut[9]  = 7'h7B; lut[10] = 7'h77; lut[11] = 7'h1F;
    lut[12] = 7'h4E; lut[13] = 7'h3D; lut[14] = 7'h4F; lut[15] = 7'h47;
  end

  // Registered decoder, latency 1
  always @(posedge clk) dec_seg <= lut[dec_num];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a scan started at cycle S shows tens on the decoder bus in S+1,
  // ones from S+3, busy over S+1..S+5, and commits both digits with done at S+5.
  int         cyc = 0;
  int         m_s = -1000;
  int         m_base = 0;
  bit         m_pend = 1'b0;
  logic [3:0] m_t = 4'd0;
  logic [3:0] m_o = 4'd0;
  bit         m_b = 1'b0;
  logic [3:0] m_num = 4'd0;
  logic [6:0] m_s1 = 7'h7F;
  logic [6:0] m_s2 = 7'h7F;

  initial begin
    bit m_busy, m_done, wrap;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_s = -1000; m_pend = 1'b0; m_num = 4'd0;
        m_s1 = 7'h7F; m_s2 = 7'h7F; m_base = cyc + 1;
      end else begin
        if (cyc == m_s + 1) m_num = m_t;
        if (cyc == m_s + 3) m_num = m_o;
        if (cyc == m_s + 5) begin
          m_s1 = (m_b && m_t == 4'd0) ? 7'h7F : ~lut[m_t];
          m_s2 = ~lut[m_o];
        end
      end
      m_busy = rst_n && (cyc >= m_s + 1) && (cyc <= m_s + 5);
      m_done = rst_n && (cyc == m_s + 5);
      chk("model_seg1", seg1, m_s1);
      chk("model_seg2", seg2, m_s2);
      chk("model_dec_num", dec_num, m_num);
      chk("model_busy", busy, m_busy);
      chk("model_done", done, m_done);
      if (rst_n) begin
        wrap = (((cyc - m_base) % RC) == RC - 1);
        if (m_busy && upd) m_pend = 1'b1;
        if (!m_busy && (wrap || upd || m_pend)) begin
          m_s = cyc; m_t = tens; m_o = ones; m_b = blank;
          m_pend = 1'b0; m_base = cyc + 1;
        end
      end
    end
  end

  task automatic wait_done(input string name, output int n);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: no o_Done after %0d cycles, expected one", name, n);
    end
  endtask

  // Pulse i_Update for one cycle and return cycles-to-done plus decoder bus samples.
  task automatic pulse_and_wait(input string name, output int lat, output logic [3:0] n1,
                                output logic [3:0] n3);
    @(posedge clk); #1 upd = 1'b1;
    @(posedge clk); #1 upd = 1'b0;
    lat = 0; n1 = 4'hx; n3 = 4'hx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) n1 = dec_num;
      if (lat == 3) n3 = dec_num;
      if (done) break;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_timeout: no o_Done after %0d cycles, expected one", name, lat);
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, m;
    logic [3:0] n1, n3;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_seg1", seg1, 7'h7F);
    chk("reset_seg2", seg2, 7'h7F);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_dec_num", dec_num, 4'd0);

    // 42 displayed
    tens = 4'd4; ones = 4'd2; blank = 1'b0;
    pulse_and_wait("t1", lat, n1, n3);
    chk("t1_latency", lat, 5);
    chk("t1_dec_tens", n1, 4'd4);
    chk("t1_dec_ones", n3, 4'd2);
    chk("t1_seg1", seg1, 7'h4C);
    chk("t1_seg2", seg2, 7'h12);
    $display("t1: 42 -> seg1=%h seg2=%h latency=%0d", seg1, seg2, lat);

    // 07 with and without leading-zero blanking
    tens = 4'd0; ones = 4'd7; blank = 1'b1;
    pulse_and_wait("t2a", lat, n1, n3);
    chk("t2a_latency", lat, 5);
    chk("t2a_seg1", seg1, 7'h7F);
    chk("t2a_seg2", seg2, 7'h0F);
    $display("t2a: 07 blanked -> seg1=%h seg2=%h", seg1, seg2);
    blank = 1'b0;
    pulse_and_wait("t2b", lat, n1, n3);
    chk("t2b_latency", lat, 5);
    chk("t2b_seg1", seg1, 7'h01);
    chk("t2b_seg2", seg2, 7'h0F);
    $display("t2b: 07 unblanked -> seg1=%h seg2=%h", seg1, seg2);

    // Automatic refresh every RC cycles; mid-scan input change only shows next time
    tens = 4'd9; ones = 4'd9;
    wait_done("t3a", n);
    chk("t3_period1", n, 16);
    chk("t3a_seg1", seg1, 7'h04);
    chk("t3a_seg2", seg2, 7'h04);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n++;
      if (busy) break;
    end
    @(posedge clk); #1 ones = 4'd3;
    wait_done("t3b", m);
    chk("t3_period2", n + m, 16);
    chk("t3b_seg2", seg2, 7'h04);
    wait_done("t3c", n);
    chk("t3_period3", n, 16);
    chk("t3c_seg1", seg1, 7'h04);
    chk("t3c_seg2", seg2, 7'h06);
    $display("t3: refresh period=%0d seg1=%h seg2=%h", n, seg1, seg2);

    // Two requests while busy collapse into one follow-up scan
    @(posedge clk); #1 upd = 1'b1;
    @(posedge clk); #1 upd = 1'b0;
    @(posedge clk); #1 upd = 1'b1;
    @(posedge clk); #1 upd = 1'b0;
    @(posedge clk); #1 upd = 1'b1;
    @(posedge clk); #1 upd = 1'b0;
    wait_done("t4a", n);
    chk("t4_first_done", n, 1);
    wait_done("t4b", n);
    chk("t4_gap", n, 6);
    count_dones(10, n);
    chk("t4_no_extra", n, 0);
    $display("t4: pending rescan gap checked, extra dones=%0d", n);

    // Update lands exactly on the refresh wrap cycle
    wait_done("t5sync", n);
    repeat (10) @(posedge clk);
    @(posedge clk); #1 upd = 1'b1;
    @(posedge clk); #1 upd = 1'b0;
    wait_done("t5", n);
    chk("t5_latency", n, 5);
    count_dones(10, n);
    chk("t5_single", n, 0);
    $display("t5: wrap+update collision, extra dones=%0d", n);

    // Asynchronous reset in the middle of a scan
    tens = 4'd1; ones = 4'd5;
    @(posedge clk); #1 upd = 1'b1;
    @(posedge clk); #1 upd = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_seg1", seg1, 7'h7F);
    chk("t6_rst_seg2", seg2, 7'h7F);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    pulse_and_wait("t6", lat, n1, n3);
    chk("t6_latency", lat, 5);
    chk("t6_seg1", seg1, 7'h4F);
    chk("t6_seg2", seg2, 7'h24);
    $display("t6: after reset 15 -> seg1=%h seg2=%h", seg1, seg2);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
